integer_divide_control: RTL and testbench



---
 rtl/integer_divide_control.sv | 175 +++++++++++++++++
 tb/tb_integer_divide_control.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/integer_divide_control.sv
// Two's-complement DIV/DIVU/REM/REMU control wrapped around a sign-magnitude multicycle divider.
// Define INTEGER_DIVIDE_FAST_PATH_EN to resolve zero-divisor and signed-overflow requests without the divider.
module integer_divide_control #(
  parameter int OPERAND_WIDTH_IN_BITS = 64
) (
  input  logic                             clk_in,
  input  logic                             reset_in,
  // request side
  input  logic                             request_valid_in,
  input  logic [1:0]                       request_op_in,
  input  logic [OPERAND_WIDTH_IN_BITS-1:0] dividend_in,
  input  logic [OPERAND_WIDTH_IN_BITS-1:0] divisor_in,
  output logic                             request_ack_out,
  // divider side
  output logic                             valid_to_div_out,
  output logic                             dividend_sign_to_div_out,
  output logic [OPERAND_WIDTH_IN_BITS-1:0] dividend_to_div_out,
  output logic                             divisor_sign_to_div_out,
  output logic [OPERAND_WIDTH_IN_BITS-1:0] divisor_to_div_out,
  input  logic                             valid_from_div_in,
  input  logic                             quotient_sign_from_div_in,
  input  logic [OPERAND_WIDTH_IN_BITS-1:0] quotient_from_div_in,
  input  logic                             remainder_sign_from_div_in,
  input  logic [OPERAND_WIDTH_IN_BITS-1:0] remainder_from_div_in,
  input  logic                             divide_by_zero_from_div_in,
  // result side
  output logic                             result_valid_out,
  output logic [OPERAND_WIDTH_IN_BITS-1:0] result_out,
  input  logic                             result_ack_in
);

  localparam int W = OPERAND_WIDTH_IN_BITS;
  localparam logic [W-1:0] ONE           = W'(1);
  localparam logic [W-1:0] MOST_NEGATIVE = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef struct packed {
    logic         sign;
    logic [W-1:0] mag;
  } sign_mag_t;

  // op[1] selects remainder, op[0] selects unsigned
  function automatic sign_mag_t to_sign_mag(input logic is_signed, input logic [W-1:0] value);
    sign_mag_t sm;
    sm.sign = is_signed & value[W-1];
    sm.mag  = sm.sign ? (~value + ONE) : value;
    return sm;
  endfunction

  function automatic logic [W-1:0] restore_twos(input logic sign, input logic [W-1:0] mag);
    return sign ? (~mag + ONE) : mag;
  endfunction

  function automatic logic [W-1:0] zero_divisor_result(input logic is_rem,
                                                       input logic [W-1:0] dividend);
    return is_rem ? dividend : {W{1'b1}};
  endfunction

  state_e       state_q, state_d;
  logic [1:0]   op_q, op_d;
  logic [W-1:0] dividend_q, dividend_d;
  sign_mag_t    dividend_sm_q, dividend_sm_d;
  sign_mag_t    divisor_sm_q, divisor_sm_d;
  logic [W-1:0] result_q, result_d;

  sign_mag_t    req_dividend_sm;
  sign_mag_t    req_divisor_sm;
  logic [W-1:0] div_selected;

  assign req_dividend_sm = to_sign_mag(~request_op_in[0], dividend_in);
  assign req_divisor_sm  = to_sign_mag(~request_op_in[0], divisor_in);

  assign div_selected = op_q[1] ?
                        restore_twos(remainder_sign_from_div_in, remainder_from_div_in) :
                        restore_twos(quotient_sign_from_div_in, quotient_from_div_in);

`ifdef INTEGER_DIVIDE_FAST_PATH_EN
  logic fast_zero_divisor;
  logic fast_overflow;
  logic unused_divide_by_zero;

  assign fast_zero_divisor     = (divisor_in == '0);
  assign fast_overflow         = ~request_op_in[0] & (dividend_in == MOST_NEGATIVE) &
                                 (divisor_in == {W{1'b1}});
  assign unused_divide_by_zero = divide_by_zero_from_div_in;
`endif

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
    state_d       = state_q;
    op_d          = op_q;
    dividend_d    = dividend_q;
    dividend_sm_d = dividend_sm_q;
    divisor_sm_d  = divisor_sm_q;
    result_d      = result_q;

    case (state_q)
      IDLE: begin
        if (request_valid_in) begin
          op_d          = request_op_in;
          dividend_d    = dividend_in;
          dividend_sm_d = req_dividend_sm;
          divisor_sm_d  = req_divisor_sm;
          state_d       = ISSUE;
`ifdef INTEGER_DIVIDE_FAST_PATH_EN
          if (fast_zero_divisor) begin
            result_d = zero_divisor_result(request_op_in[1], dividend_in);
            state_d  = RESP;
          end else if (fast_overflow) begin
            result_d = request_op_in[1] ? '0 : MOST_NEGATIVE;
            state_d  = RESP;
          end
`endif
        end
      end

      ISSUE: state_d = WAIT;

      WAIT: begin
        if (valid_from_div_in) begin
`ifdef INTEGER_DIVIDE_FAST_PATH_EN
          result_d = div_selected;
`else
          result_d = divide_by_zero_from_div_in ? zero_divisor_result(op_q[1], dividend_q)
                                                : div_selected;
`endif
          state_d  = RESP;
        end
      end

      RESP: begin
        if (result_ack_in) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    // NOTE: flops take non-blocking assignments so every register samples pre-edge values.
    if (reset_in) begin
      state_q       <= IDLE;
      op_q          <= '0;
      dividend_q    <= '0;
      dividend_sm_q <= '0;
      divisor_sm_q  <= '0;
      result_q      <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      dividend_q    <= dividend_d;
      dividend_sm_q <= dividend_sm_d;
      divisor_sm_q  <= divisor_sm_d;
      result_q      <= result_d;
    end
  end

  assign request_ack_out  = (state_q == IDLE);
  assign valid_to_div_out = (state_q == ISSUE);
  assign result_valid_out = (state_q == RESP);
  assign result_out       = result_q;

  // divider fields read as zero outside the issue pulse
  assign dividend_sign_to_div_out = valid_to_div_out & dividend_sm_q.sign;
  assign dividend_to_div_out      = valid_to_div_out ? dividend_sm_q.mag : '0;
  assign divisor_sign_to_div_out  = valid_to_div_out & divisor_sm_q.sign;
  assign divisor_to_div_out       = valid_to_div_out ? divisor_sm_q.mag : '0;

endmodule

// File: tb/tb_integer_divide_control.sv
// Self-checking bench for integer_divide_control: directed test-plan cases plus randomized requests,
// with a behavioural sign-magnitude divider model and an arithmetic reference for results.
module tb_integer_divide_control;

  localparam int W = 64;
  localparam logic [W-1:0] MIN_VAL  = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] ALL_ONES = {W{1'b1}};
`ifdef INTEGER_DIVIDE_FAST_PATH_EN
  localparam bit FAST_EN = 1'b1;
`else
  localparam bit FAST_EN = 1'b0;
`endif

  logic         clk_in = 1'b0;
  logic         reset_in;
  logic         request_valid_in;
  logic [1:0]   request_op_in;
  logic [W-1:0] dividend_in;
  logic [W-1:0] divisor_in;
  logic         request_ack_out;
  logic         valid_to_div_out;
  logic         dividend_sign_to_div_out;
  logic [W-1:0] dividend_to_div_out;
  logic         divisor_sign_to_div_out;
  logic [W-1:0] divisor_to_div_out;
  logic         valid_from_div_in;
  logic         quotient_sign_from_div_in;
  logic [W-1:0] quotient_from_div_in;
  logic         remainder_sign_from_div_in;
  logic [W-1:0] remainder_from_div_in;
  logic         divide_by_zero_from_div_in;
  logic         result_valid_out;
  logic [W-1:0] result_out;
  logic         result_ack_in;

  logic model_valid = 1'b0;
  logic stray_valid;
  int   lat_cfg;
  int   model_cnt = 0;
  bit   model_busy = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  integer_divide_control #(.OPERAND_WIDTH_IN_BITS(W)) dut (
    .clk_in                     (clk_in),
    .reset_in                   (reset_in),
    .request_valid_in           (request_valid_in),
    .request_op_in              (request_op_in),
    .dividend_in                (dividend_in),
    .divisor_in                 (divisor_in),
    .request_ack_out            (request_ack_out),
    .valid_to_div_out           (valid_to_div_out),
    .dividend_sign_to_div_out   (dividend_sign_to_div_out),
    .dividend_to_div_out        (dividend_to_div_out),
    .divisor_sign_to_div_out    (divisor_sign_to_div_out),
    .divisor_to_div_out         (divisor_to_div_out),
    .valid_from_div_in          (valid_from_div_in),
    .quotient_sign_from_div_in  (quotient_sign_from_div_in),
    .quotient_from_div_in       (quotient_from_div_in),
    .remainder_sign_from_div_in (remainder_sign_from_div_in),
    .remainder_from_div_in      (remainder_from_div_in),
    .divide_by_zero_from_div_in (divide_by_zero_from_div_in),
    .result_valid_out           (result_valid_out),
    .result_out                 (result_out),
    .result_ack_in              (result_ack_in)
  );

  always #5 clk_in = ~clk_in;

  assign valid_from_div_in = model_valid | stray_valid;

  // Sign-magnitude divider model with configurable latency; shares reset with the DUT.
  always @(negedge clk_in) begin
    if (reset_in) begin
      model_busy  <= 1'b0;
      model_valid <= 1'b0;
      model_cnt   <= 0;
    end else begin
      model_valid <= model_busy && (model_cnt == 1);
      if (model_busy) begin
        model_cnt <= model_cnt - 1;
        if (model_cnt == 1) model_busy <= 1'b0;
      end
      if (valid_to_div_out) begin
        model_busy <= 1'b1;
        model_cnt  <= lat_cfg;
        if (divisor_to_div_out == '0) begin
          divide_by_zero_from_div_in <= 1'b1;
          quotient_sign_from_div_in  <= 1'b0;
          quotient_from_div_in       <= ALL_ONES;
          remainder_sign_from_div_in <= 1'b0;
          remainder_from_div_in      <= dividend_to_div_out;
        end else begin
          divide_by_zero_from_div_in <= 1'b0;
          quotient_sign_from_div_in  <= dividend_sign_to_div_out ^ divisor_sign_to_div_out;
          quotient_from_div_in       <= dividend_to_div_out / divisor_to_div_out;
          remainder_sign_from_div_in <= dividend_sign_to_div_out;
          remainder_from_div_in      <= dividend_to_div_out % divisor_to_div_out;
        end
      end
    end
  end

  // Architectural result straight from the operation definitions.
  function automatic logic [W-1:0] ref_result(input logic [1:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    sa = a;
    sb = b;
    if (b == '0) return op[1] ? a : ALL_ONES;
    if (op[0]) return op[1] ? (a % b) : (a / b);
    if (a == MIN_VAL && b == ALL_ONES) return op[1] ? '0 : MIN_VAL;
    return op[1] ? W'(sa % sb) : W'(sa / sb);
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Starts and ends 1 time unit after a rising edge.
  task automatic do_req(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int lat, input int hold);
    logic [W-1:0] exp_res;
    logic         exp_ds, exp_vs;
    logic [W-1:0] exp_dm, exp_vm;
    bit           fast;
    bit           quiet;
    bit           stable;
    int           n;
    exp_res = ref_result(op, a, b);
    exp_ds  = !op[0] && a[W-1];
    exp_vs  = !op[0] && b[W-1];
    exp_dm  = exp_ds ? (0 - a) : a;
    exp_vm  = exp_vs ? (0 - b) : b;
    fast    = FAST_EN && ((b == '0) || (!op[0] && a == MIN_VAL && b == ALL_ONES));
    lat_cfg = lat;

    request_valid_in = 1'b1;
    request_op_in    = op;
    dividend_in      = a;
    divisor_in       = b;
    check("req_ack_idle", W'(request_ack_out), W'(1));
    @(posedge clk_in); #1;
    request_valid_in = 1'b0;

    if (fast) begin
      check("fast_no_issue", W'(valid_to_div_out), W'(0));
      check("fast_result_valid_t1", W'(result_valid_out), W'(1));
    end else begin
      check("issue_valid_t1", W'(valid_to_div_out), W'(1));
      check("issue_dividend_sign", W'(dividend_sign_to_div_out), W'(exp_ds));
      check("issue_dividend_mag", dividend_to_div_out, exp_dm);
      check("issue_divisor_sign", W'(divisor_sign_to_div_out), W'(exp_vs));
      check("issue_divisor_mag", divisor_to_div_out, exp_vm);
      n = 0;
      quiet = 1'b1;
      while (!result_valid_out && n < 64) begin
        @(posedge clk_in); #1;
        n++;
        if (valid_to_div_out || dividend_sign_to_div_out || divisor_sign_to_div_out ||
            dividend_to_div_out != '0 || divisor_to_div_out != '0) quiet = 1'b0;
      end
      check("result_latency", W'(n), W'(lat + 1));
      check("div_fields_zero_after_issue", W'(quiet), W'(1));
    end

    check("result_value", result_out, exp_res);
    check("no_ack_in_resp", W'(request_ack_out), W'(0));

    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      request_valid_in = 1'b1;
      request_op_in    = 2'($urandom_range(0, 3));
      dividend_in      = {$urandom, $urandom};
      divisor_in       = 1;
      @(posedge clk_in); #1;
      if (result_out !== exp_res || result_valid_out !== 1'b1 || request_ack_out !== 1'b0 ||
          valid_to_div_out !== 1'b0) stable = 1'b0;
    end
    if (hold > 0) check("resp_hold_stable", W'(stable), W'(1));

    request_valid_in = 1'b0;
    result_ack_in    = 1'b1;
    @(posedge clk_in); #1;
    result_ack_in = 1'b0;
    check("idle_after_ack", W'(request_ack_out), W'(1));
    check("valid_drop_after_ack", W'(result_valid_out), W'(0));
  endtask

  initial begin
    logic [1:0]   op;
    logic [W-1:0] a, b;
    int           kind;

    reset_in         = 1'b1;
    request_valid_in = 1'b0;
    request_op_in    = 2'b00;
    dividend_in      = '0;
    divisor_in       = '0;
    result_ack_in    = 1'b0;
    stray_valid      = 1'b0;
    lat_cfg          = 3;
    divide_by_zero_from_div_in = 1'b0;
    quotient_sign_from_div_in  = 1'b0;
    quotient_from_div_in       = '0;
    remainder_sign_from_div_in = 1'b0;
    remainder_from_div_in      = '0;

    repeat (3) @(posedge clk_in);
    #1;
    check("rst_request_ack", W'(request_ack_out), W'(1));
    check("rst_valid_to_div", W'(valid_to_div_out), W'(0));
    check("rst_result_valid", W'(result_valid_out), W'(0));
    check("rst_result", result_out, '0);
    check("rst_dividend_to_div", dividend_to_div_out, '0);
    reset_in = 1'b0;
    @(posedge clk_in); #1;

    // test-plan directed cases
    do_req(2'b00, -64'sd7, 64'd2, 3, 0);
    do_req(2'b10, -64'sd7, 64'd2, 2, 0);
    do_req(2'b01, 64'd100, 64'd7, 4, 0);
    do_req(2'b11, 64'd100, 64'd7, 1, 0);
    do_req(2'b00, 64'd5, 64'd0, 3, 0);
    do_req(2'b11, 64'h1234, 64'd0, 3, 0);
    do_req(2'b10, -64'sd9, 64'd0, 2, 0);
    do_req(2'b00, MIN_VAL, ALL_ONES, 3, 0);
    do_req(2'b10, MIN_VAL, ALL_ONES, 3, 0);
    do_req(2'b01, MIN_VAL, ALL_ONES, 2, 0);
    do_req(2'b00, -64'sd100, -64'sd7, 5, 10);
    do_req(2'b10, 64'd100, -64'sd7, 1, 0);

    // reset during WAIT, then a stray divider pulse in IDLE
    lat_cfg          = 8;
    request_valid_in = 1'b1;
    request_op_in    = 2'b00;
    dividend_in      = 64'd100;
    divisor_in       = 64'd7;
    @(posedge clk_in); #1;
    request_valid_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    reset_in = 1'b1;
    @(posedge clk_in); #1;
    reset_in = 1'b0;
    check("midrst_request_ack", W'(request_ack_out), W'(1));
    check("midrst_result_valid", W'(result_valid_out), W'(0));
    check("midrst_result_cleared", result_out, '0);
    stray_valid = 1'b1;
    @(posedge clk_in); #1;
    stray_valid = 1'b0;
    check("stray_ignored_valid", W'(result_valid_out), W'(0));
    check("stray_ignored_ack", W'(request_ack_out), W'(1));
    repeat (10) @(posedge clk_in);
    #1;
    check("no_late_result", W'(result_valid_out), W'(0));

    // randomized requests
    for (int t = 0; t < 40; t++) begin
      op   = 2'($urandom_range(0, 3));
      kind = $urandom_range(0, 9);
      a    = {$urandom, $urandom};
      b    = {$urandom, $urandom} >> $urandom_range(0, 62);
      if (kind == 0) b = '0;
      if (kind == 1) begin
        a = MIN_VAL;
        b = ALL_ONES;
      end
      if (kind == 2) b = 0 - W'($urandom_range(1, 20));
      if (kind == 3) a = 0 - W'($urandom_range(0, 1000));
      do_req(op, a, b, $urandom_range(1, 6), $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
